// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the 64-bit pipelined adder and its result buffer.
// Result word is {carry, sum}, RES_W bits wide.
package adder_pipe_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int PIPE_LAT   = 4;
    localparam int RES_W      = DATA_WIDTH + 1;

    typedef struct packed {
        logic                  carry;
        logic [DATA_WIDTH-1:0] sum;
    } add_res_t;

    function automatic add_res_t add_res(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        add_res_t r;
        {r.carry, r.sum} = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

endpackage

// File: rtl/adder_result_fifo_mem.sv
// Register-array storage for the adder result FIFO.
// One synchronous write port, one asynchronous read port.
module adder_result_fifo_mem
    import adder_pipe_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [RES_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [RES_W-1:0] rdata
);

    logic [RES_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adder_result_buffer.sv
// Result FIFO behind the pipelined adder: captures results on res_en,
// presents them valid/ready, and issues credit for new operands.
module adder_result_buffer
    import adder_pipe_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue_en,
    output logic                       issue_ok,
    input  logic                       res_en,
    input  logic [RES_W-1:0]           res_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [RES_W-1:0]           m_data,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       err_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(2 * DEPTH + 1);

    localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);
    localparam logic [SW-1:0] CRED_LIM = SW'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    inflight;
    logic             err_q;
    logic [RES_W-1:0] head;
    logic [SW-1:0]    occ;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             err_set;

    assign full  = (fill_q == FULL_CNT);
    assign empty = (fill_q == '0);
    assign pop   = !empty && m_ready;
    // A full FIFO still accepts a write when the head leaves this cycle.
    assign push  = res_en && (!full || pop);

    assign occ      = SW'(fill_q) + SW'(inflight);
    assign issue_ok = (occ < CRED_LIM);

    assign err_set = (issue_en && !issue_ok)
                   || (res_en && full && !pop)
                   || (res_en && (inflight == '0));

    assign m_valid = !empty;
    assign m_data  = m_valid ? head : '0;
    assign fill    = fill_q;
    assign err_ovf = err_q;

    adder_result_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (res_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   fill_q <= fill_q + FW'(1);
                2'b01:   fill_q <= fill_q - FW'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Counter saturates so protocol violations cannot wrap it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (issue_en && !res_en) begin
            if (inflight != FULL_CNT) begin
                inflight <= inflight + FW'(1);
            end
        end else if (res_en && !issue_en) begin
            if (inflight != '0) begin
                inflight <= inflight - FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_result_buffer.sv
// Randomized bench for adder_result_buffer with an adder pipe model
// and a queue-based reference of the buffer.
module tb_adder_result_buffer;
    import adder_pipe_pkg::*;

    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_en = 1'b0;
    logic             issue_ok;
    logic             res_en = 1'b0;
    logic [RES_W-1:0] res_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [RES_W-1:0] m_data;
    logic [3:0]       fill;
    logic             err_ovf;

    always #5 clk = ~clk;

    adder_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue_en (issue_en),
        .issue_ok (issue_ok),
        .res_en   (res_en),
        .res_data (res_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .fill     (fill),
        .err_ovf  (err_ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [RES_W-1:0] got,
                         logic [RES_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [RES_W-1:0] q[$];
    int               infl;
    bit               merr;
    int               pops;
    int               issued;
    bit               pv[PIPE_LAT];
    logic [RES_W-1:0] pd[PIPE_LAT];
    logic [63:0]      na;
    logic [63:0]      nb;

    function automatic bit m_ok();
        return (q.size() + infl) < DEPTH;
    endfunction

    task automatic model_clear();
        q.delete();
        infl = 0;
        merr = 0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            pv[i] = 0;
            pd[i] = '0;
        end
    endtask

    task automatic check_outputs();
        check("issue_ok", issue_ok, m_ok());
        check("m_valid", m_valid, q.size() > 0);
        check("m_data", m_data, (q.size() > 0) ? q[0] : '0);
        check("fill", fill, q.size());
        check("err_ovf", err_ovf, merr);
    endtask

    task automatic new_ops();
        na = {$urandom, $urandom};
        nb = {$urandom, $urandom};
    endtask

    task automatic cyc(bit want, bit force_iss, bit rdy,
                       bit inject = 0, logic [RES_W-1:0] inj_d = '0);
        bit ok;
        bit pop;
        @(negedge clk);
        check_outputs();
        issue_en = force_iss || (want && m_ok());
        m_ready  = rdy;
        res_en   = pv[PIPE_LAT-1] || inject;
        res_data = inject ? inj_d : pd[PIPE_LAT-1];
        @(posedge clk);
        ok  = m_ok();
        pop = (q.size() > 0) && m_ready;
        if (issue_en && !ok) merr = 1;
        if (res_en && infl == 0) merr = 1;
        if (pop) begin
            void'(q.pop_front());
            pops++;
        end
        if (res_en) begin
            if (q.size() < DEPTH) q.push_back(res_data);
            else merr = 1;
        end
        if (issue_en) infl++;
        if (res_en && infl > 0) infl--;
        if (issue_en) issued++;
        for (int i = PIPE_LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = issue_en;
        pd[0] = {1'b0, na} + {1'b0, nb};
        if (issue_en) new_ops();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        issue_en = 1'b0;
        res_en   = 1'b0;
        m_ready  = 1'b0;
        res_data = '0;
        model_clear();
        #1;
        check_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        new_ops();
        model_clear();
        pops = 0;
        issued = 0;

        // 1: reset values
        do_reset();
        check("rst_issue_ok", issue_ok, 1'b1);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, '0);
        check("rst_fill", fill, '0);
        check("rst_err", err_ovf, 1'b0);

        // 2: single result with carry
        na = 64'hFFFF_FFFF_FFFF_FFFF;
        nb = 64'h2;
        cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        #1;
        check("single_pre_valid", m_valid, 1'b0);
        cyc(0, 0, 0);
        #1;
        check("single_valid", m_valid, 1'b1);
        check("single_data", m_data, 65'h1_0000_0000_0000_0001);
        check("single_fill1", fill, 4'd1);
        cyc(0, 0, 1);
        #1;
        check("single_fill0", fill, 4'd0);

        // 3: fill to full with m_ready low
        do_reset();
        repeat (8) cyc(1, 0, 0);
        #1;
        check("full_ok_drop", issue_ok, 1'b0);
        check("full_inflight", fill < 4'd8, 1'b1);
        repeat (6) cyc(1, 0, 0);
        #1;
        check("full_fill8", fill, 4'd8);
        check("full_err0", err_ovf, 1'b0);
        pops = 0;
        repeat (10) cyc(0, 0, 1);
        check("full_drained", pops, 8);

        // 4: wrap with toggling m_ready
        do_reset();
        pops = 0;
        issued = 0;
        for (int c = 0; c < 400 && pops < 20; c++) begin
            cyc(issued < 20, 0, (c % 2) == 0);
        end
        check("wrap_issued", issued, 20);
        check("wrap_popped", pops, 20);

        // 5: full plus simultaneous push and pop
        do_reset();
        repeat (8) cyc(1, 0, 0);
        repeat (6) cyc(0, 0, 0);
        cyc(0, 0, 1, 1, 65'h0_DEAD_BEEF_0BAD_F00D);
        #1;
        check("pp_fill8", fill, 4'd8);
        repeat (7) cyc(0, 0, 1);
        #1;
        check("pp_tail", m_data, 65'h0_DEAD_BEEF_0BAD_F00D);
        repeat (3) cyc(0, 0, 1);

        // 6: forced issue without credit, then mid-stream reset
        do_reset();
        repeat (8) cyc(1, 0, 0);
        repeat (6) cyc(0, 0, 0);
        cyc(0, 1, 0);
        #1;
        check("err_set", err_ovf, 1'b1);
        repeat (8) cyc(0, 0, 0);
        do_reset();
        for (int c = 0; c < 300; c++) begin
            cyc($urandom_range(0, 3) != 0, 0, $urandom_range(0, 2) != 0);
        end
        cyc(1, 0, 0);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        issue_en = 1'b0;
        res_en   = 1'b0;
        m_ready  = 1'b0;
        #1;
        check("mid_rst_ok", issue_ok, 1'b1);
        check("mid_rst_valid", m_valid, 1'b0);
        check("mid_rst_data", m_data, '0);
        check("mid_rst_fill", fill, '0);
        check("mid_rst_err", err_ovf, 1'b0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 200; c++) begin
            cyc($urandom_range(0, 1) != 0, 0, $urandom_range(0, 1) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
